// File: rtl/rf_pkg.sv
// Shared definitions for the register file.
//   rf_state_e : clear-sequencer state encoding
//   RF_*       : default parameter values for register_file
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_READ = 2;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on request.
//   clk        : clock
//   rst_n      : async active-low reset, restarts the sweep at entry 0
//   clear_i    : request a new sweep (honoured in IDLE only)
//   clr_we_o   : high while sweeping; storage writes zero at clr_addr_o
//   clr_addr_o : entry cleared on the current edge
//   ready_o    : high in IDLE
//
// state    | meaning
// ---------+------------------------------------------------------
// RF_CLEAR | zeroing entry clear_ptr each edge, writes ignored
// RF_IDLE  | normal operation, writes and reads serviced
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clear_ptr_q;
  logic              ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RF_CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          clear_ptr_q <= clear_ptr_q + 1'b1;
          // Leave on the edge that zeroes the last entry: DEPTH edges per sweep.
          if (clear_ptr_q == '1) begin
            state_q <= RF_IDLE;
            ready_q <= 1'b1;
          end
        end
        RF_IDLE: begin
          if (clear_i) begin
            state_q     <= RF_CLEAR;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= RF_CLEAR;
          clear_ptr_q <= '0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // ready_q is exactly "state is IDLE", so the sweep enable is its inverse.
  assign clr_we_o   = ~ready_q;
  assign clr_addr_o = clear_ptr_q;
  assign ready_o    = ready_q;

endmodule

// File: rtl/register_file.sv
// Multi-read, single-write register file with hardware clear sweep.
//   clk      : clock
//   rst_n    : async active-low reset (storage is not reset, it is swept)
//   write    : write enable, waddr / data_in : write address / data
//   raddr    : N_READ packed read addresses
//   data_out : N_READ packed registered read data (1-cycle latency)
//   clear    : request a zeroing sweep of every entry
//   ready    : high when idle and accepting writes
// Entry 0 is hard-wired to read as zero.
module register_file
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int N_READ = RF_N_READ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [N_READ*ADDR_W-1:0] raddr,
  output logic [N_READ*DATA_W-1:0] data_out,
  input  logic                     clear,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [N_READ*DATA_W-1:0] data_out_d;
  logic [N_READ*DATA_W-1:0] data_out_q;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  // User writes only in IDLE and never to entry 0.
  assign user_we = write && !clr_we && (waddr != '0);

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (user_we) begin
      mem_q[waddr] <= data_in;
    end
  end

  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < N_READ; i++) begin
      if (clr_we) begin
        data_out_d[i*DATA_W +: DATA_W] = '0;
      end else if (user_we && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
        // Write-through so a same-edge read sees the new value.
        data_out_d[i*DATA_W +: DATA_W] = data_in;
      end else if (raddr[i*ADDR_W +: ADDR_W] == '0) begin
        data_out_d[i*DATA_W +: DATA_W] = '0;
      end else begin
        data_out_d[i*DATA_W +: DATA_W] = mem_q[raddr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int N_READ = 2;
  localparam int DEPTH  = 32;

  logic                     clk;
  logic                     rst_n;
  logic                     write;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        data_in;
  logic [N_READ*ADDR_W-1:0] raddr;
  logic [N_READ*DATA_W-1:0] data_out;
  logic                     clear;
  logic                     ready;

  int n_vec = 0;
  int n_err = 0;

  register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_READ (N_READ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write    (write),
    .waddr    (waddr),
    .data_in  (data_in),
    .raddr    (raddr),
    .data_out (data_out),
    .clear    (clear),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    write   = 1'b1;
    waddr   = a;
    data_in = d;
    step();
    write   = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] e0,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] e1);
    set_raddr(a0, a1);
    step();
    chk({tag, "_p0"}, 32'(data_out[7:0]), 32'(e0));
    chk({tag, "_p1"}, 32'(data_out[15:8]), 32'(e1));
  endtask

  // Sweep from the current point: ready must stay low until the 32nd edge.
  task automatic sweep_chk(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      chk(tag, 32'(ready), (k == DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_chk(tag, 5'(a), 8'h00, 5'(DEPTH - 1 - a), 8'h00);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    waddr   = '0;
    data_in = '0;
    raddr   = '0;
    clear   = 1'b0;

    #2;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Power-up sweep and blank contents.
    sweep_chk("rdy_init");
    read_all_zero("init_zero");

    // Basic write/read with an untouched neighbour.
    wr(5'd4, 8'h04);
    rd_chk("rd4", 5'd4, 8'h04, 5'd1, 8'h00);

    // Same-edge bypass, then the stored value without bypass.
    set_raddr(5'd7, 5'd4);
    wr(5'd7, 8'hA5);
    chk("bypass_p0", 32'(data_out[7:0]), 32'h00A5);
    chk("bypass_p1", 32'(data_out[15:8]), 32'h0004);
    rd_chk("same_addr", 5'd7, 8'hA5, 5'd7, 8'hA5);

    // Entry 0 ignores writes, including a same-edge read of it.
    set_raddr(5'd0, 5'd4);
    wr(5'd0, 8'hFF);
    chk("zero_bypass", 32'(data_out[7:0]), 32'h0000);
    rd_chk("zero_rd", 5'd0, 8'h00, 5'd4, 8'h04);

    // Fill 1..31 with their own index.
    for (int a = 1; a < DEPTH; a++) wr(5'(a), 8'(a));
    rd_chk("fill_a", 5'd17, 8'd17, 5'd31, 8'd31);
    rd_chk("fill_b", 5'd1, 8'd1, 5'd3, 8'd3);

    // Clear pulse coinciding with an IDLE write (write lands, sweep erases it).
    clear   = 1'b1;
    write   = 1'b1;
    waddr   = 5'd2;
    data_in = 8'h77;
    set_raddr(5'd3, 5'd5);
    step();
    clear = 1'b0;
    write = 1'b0;
    chk("clr_enter", 32'(ready), 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      // Late write to an already-cleared entry must be dropped; re-clear ignored.
      write   = (k == 20);
      waddr   = 5'd3;
      data_in = 8'h55;
      clear   = (k == 5);
      step();
      write = 1'b0;
      clear = 1'b0;
      chk("rdy_clr", 32'(ready), (k == DEPTH) ? 32'd1 : 32'd0);
      chk("dout_clr", 32'(data_out), 32'd0);
    end
    read_all_zero("clr_zero");

    // Reset at sweep edge 10 restarts the sweep.
    wr(5'd9, 8'h99);
    rd_chk("pre_rst", 5'd9, 8'h99, 5'd0, 8'h00);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_dout", 32'(data_out), 32'd0);
    step();
    rst_n = 1'b1;
    sweep_chk("rdy_rst");
    rd_chk("post_rst", 5'd9, 8'h00, 5'd31, 8'h00);

    // Reset from IDLE clears registered read data immediately.
    wr(5'd12, 8'h3C);
    rd_chk("idle_rd", 5'd12, 8'h3C, 5'd12, 8'h3C);
    rst_n = 1'b0;
    #1;
    chk("idle_rst_dout", 32'(data_out), 32'd0);
    chk("idle_rst_ready", 32'(ready), 32'd0);
    step();
    rst_n = 1'b1;
    sweep_chk("rdy_rst2");
    rd_chk("post_rst2", 5'd12, 8'h00, 5'd4, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
